// File: rtl/inst_fetch_resp.sv
// Instruction fetch response stage: issues one bus read per pc, captures the
// instruction for IF/ID and handles stall, flush, timeout and reset.
// Optional misaligned-pc fault check is enabled by defining IFETCH_ALIGN_CHECK_EN.
module inst_fetch_resp #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic        pc_read_ready,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        fetch_fault_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DROP,
    S_VALID,
    S_SETTLE
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        pc_read_ready_q, pc_read_ready_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [7:0]  wait_inc;
  logic        misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Saturating increment of the bus wait counter.
  assign wait_inc = (wait_cnt_q == 8'hff) ? 8'hff : wait_cnt_q + 8'd1;

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d         = state_q;
    bus_req_d       = bus_req_q;
    bus_addr_d      = bus_addr_q;
    wait_cnt_d      = wait_cnt_q;
    inst_d          = inst_q;
    inst_pc_d       = inst_pc_q;
    inst_valid_d    = inst_valid_q;
    pc_read_ready_d = 1'b0;
    fetch_fault_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ce && !flush) begin
          if (misaligned) begin
            fetch_fault_d = 1'b1;
            state_d       = S_SETTLE;
          end else begin
            bus_req_d  = 1'b1;
            bus_addr_d = pc;
            wait_cnt_d = 8'd0;
            state_d    = S_REQ;
          end
        end
      end

      S_REQ, S_DROP: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          // Data is kept only if no flush was seen before or with the ack.
          if (state_q == S_REQ && !flush) begin
            inst_d       = bus_rdata;
            inst_pc_d    = bus_addr_q;
            inst_valid_d = 1'b1;
            state_d      = S_VALID;
          end else begin
            state_d = S_SETTLE;
          end
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc >= TIMEOUT_LIM) begin
            bus_req_d     = 1'b0;
            fetch_fault_d = 1'b1;
            state_d       = S_SETTLE;
          end else if (flush) begin
            state_d = S_DROP;
          end
        end
      end

      S_VALID: begin
        if (flush) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_WORD;
          state_d      = S_SETTLE;
        end else if (!stall) begin
          inst_valid_d    = 1'b0;
          inst_d          = NOP_WORD;
          pc_read_ready_d = 1'b1;
          state_d         = S_SETTLE;
        end
      end

      S_SETTLE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      bus_req_q       <= 1'b0;
      bus_addr_q      <= 32'd0;
      wait_cnt_q      <= 8'd0;
      inst_q          <= NOP_WORD;
      inst_pc_q       <= 32'd0;
      inst_valid_q    <= 1'b0;
      pc_read_ready_q <= 1'b0;
      fetch_fault_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      bus_req_q       <= bus_req_d;
      bus_addr_q      <= bus_addr_d;
      wait_cnt_q      <= wait_cnt_d;
      inst_q          <= inst_d;
      inst_pc_q       <= inst_pc_d;
      inst_valid_q    <= inst_valid_d;
      pc_read_ready_q <= pc_read_ready_d;
      fetch_fault_q   <= fetch_fault_d;
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_addr      = bus_addr_q;
  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign inst_valid_o  = inst_valid_q;
  assign pc_read_ready = pc_read_ready_q;
  assign fetch_fault_o = fetch_fault_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Self-checking bench for inst_fetch_resp: directed vector table, hand-written
// stall/flush/timeout sequences and a randomized run against a reference model.
module tb_inst_fetch_resp;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ce, stall, flush, bus_ack;
  logic [31:0] pc, bus_rdata;
  logic        pc_read_ready, bus_req, inst_valid_o, fetch_fault_o;
  logic [31:0] bus_addr, inst_o, inst_pc_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_fetch_resp #(.TIMEOUT_CYCLES(TO), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .stall(stall), .flush(flush),
    .pc_read_ready(pc_read_ready), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .fetch_fault_o(fetch_fault_o)
  );

  // Reference model: an outstanding-request flag, a discard flag, a wait age
  // and a one-cycle settle gap, stepped once per clock from the fetch rules.
  bit          m_busy, m_discard, m_settle, m_valid, m_req, m_prr, m_fault;
  int          m_wait;
  logic [31:0] m_addr, m_inst, m_ipc;

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_discard = 0; m_settle = 0; m_valid = 0; m_req = 0;
      m_prr = 0; m_fault = 0; m_wait = 0; m_addr = 0; m_inst = NOP; m_ipc = 0;
      return;
    end
    m_prr   = 0;
    m_fault = 0;
    if (m_settle) begin
      m_settle = 0;
    end else if (m_busy) begin
      if (bus_ack) begin
        m_busy = 0;
        m_req  = 0;
        if (!m_discard && !flush) begin
          m_valid = 1; m_inst = bus_rdata; m_ipc = m_addr;
        end else begin
          m_settle = 1;
        end
        m_discard = 0;
      end else begin
        m_wait = (m_wait < 255) ? m_wait + 1 : 255;
        if (m_wait >= int'(TO)) begin
          m_busy = 0; m_req = 0; m_fault = 1; m_settle = 1; m_discard = 0;
        end else if (flush) begin
          m_discard = 1;
        end
      end
    end else if (m_valid) begin
      if (flush || !stall) begin
        m_valid  = 0;
        m_inst   = NOP;
        m_prr    = !flush;
        m_settle = 1;
      end
    end else if (ce && !flush) begin
      if (ALIGN && pc[1:0] != 2'b00) begin
        m_fault = 1; m_settle = 1;
      end else begin
        m_busy = 1; m_req = 1; m_addr = pc; m_wait = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then sample #1 after the edge.
  task automatic cyc(input logic r, input logic c, input logic [31:0] p,
                     input logic s, input logic f, input logic a, input logic [31:0] d);
    rst = r; ce = c; pc = p; stall = s; flush = f; bus_ack = a; bus_rdata = d;
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, ce, stall, flush, ack;
    logic [31:0] pc, rdata;
    logic        e_req, e_valid, e_prr, e_fault;
    logic [31:0] e_addr, e_inst, e_ipc;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic r, logic c, logic [31:0] p, logic s, logic f,
                              logic a, logic [31:0] d, logic eq, logic [31:0] ea,
                              logic ev, logic [31:0] ei, logic [31:0] ep,
                              logic er, logic ef);
    vec_t v;
    v.rst = r; v.ce = c; v.pc = p; v.stall = s; v.flush = f; v.ack = a; v.rdata = d;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_ipc = ep;
    v.e_prr = er; v.e_fault = ef;
    return v;
  endfunction

  function automatic logic [127:0] dut_vec();
    return {28'd0, bus_req, bus_addr, inst_valid_o, inst_o, inst_pc_o,
            pc_read_ready, fetch_fault_o};
  endfunction

  function automatic logic [127:0] mdl_vec();
    return {28'd0, m_req, m_addr, m_valid, m_inst, m_ipc, m_prr, m_fault};
  endfunction

  initial begin
    logic [31:0] pc_reg;
    bit          ack_now;

    vecs[0]  = mk(1,0,32'h0,0,0,0,32'h0,         0,32'h0,0,NOP,32'h0,0,0);
    vecs[1]  = mk(0,1,32'hbfc00000,0,0,0,32'h0,  1,32'hbfc00000,0,NOP,32'h0,0,0);
    vecs[2]  = mk(0,1,32'hbfc00000,0,0,1,32'h3c010101,
                  0,32'hbfc00000,1,32'h3c010101,32'hbfc00000,0,0);
    vecs[3]  = mk(0,1,32'hbfc00000,0,0,0,32'h0,  0,32'hbfc00000,0,NOP,32'hbfc00000,1,0);
    vecs[4]  = mk(0,1,32'hbfc00004,0,0,0,32'h0,  0,32'hbfc00000,0,NOP,32'hbfc00000,0,0);
    vecs[5]  = mk(0,1,32'hbfc00004,0,0,0,32'h0,  1,32'hbfc00004,0,NOP,32'hbfc00000,0,0);
    vecs[6]  = mk(1,1,32'hbfc00004,0,0,0,32'h0,  0,32'h0,0,NOP,32'h0,0,0);
    vecs[7]  = mk(0,0,32'h0,0,0,1,32'hdeadbeef,  0,32'h0,0,NOP,32'h0,0,0);
    if (ALIGN)
      vecs[8] = mk(0,1,32'hbfc00002,0,0,0,32'h0, 0,32'h0,0,NOP,32'h0,0,1);
    else
      vecs[8] = mk(0,1,32'hbfc00002,0,0,0,32'h0, 1,32'hbfc00002,0,NOP,32'h0,0,0);
    vecs[9]  = mk(1,0,32'h0,0,0,0,32'h0,         0,32'h0,0,NOP,32'h0,0,0);
    vecs[10] = mk(0,0,32'h0,0,0,0,32'h0,         0,32'h0,0,NOP,32'h0,0,0);

    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].rst, vecs[i].ce, vecs[i].pc, vecs[i].stall, vecs[i].flush,
          vecs[i].ack, vecs[i].rdata);
      check($sformatf("vec%0d", i), dut_vec(),
            {28'd0, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_inst,
             vecs[i].e_ipc, vecs[i].e_prr, vecs[i].e_fault});
    end

    // Stall hold: instruction stays valid for 5 stalled cycles, then one pulse.
    cyc(0,1,32'h100,0,0,0,0);
    check("stall_req", bus_req, 1);
    cyc(0,0,32'h100,1,0,1,32'h12345678);
    check("stall_cap", {inst_valid_o, inst_o}, {1'b1, 32'h12345678});
    for (int i = 0; i < 5; i++) begin
      cyc(0,0,32'h100,1,0,0,0);
      check($sformatf("stall_hold%0d", i),
            {inst_valid_o, inst_o, inst_pc_o, pc_read_ready}, {1'b1, 32'h12345678, 32'h100, 1'b0});
    end
    cyc(0,0,32'h100,0,0,0,0);
    check("stall_release", {pc_read_ready, inst_valid_o, inst_o}, {1'b1, 1'b0, NOP});
    cyc(0,0,32'h104,0,0,0,0);
    check("stall_single_pulse", pc_read_ready, 0);

    // Flush in flight: request held until ack, data discarded, then a new request.
    cyc(0,1,32'h200,0,0,0,0);
    check("flush_req", {bus_req, bus_addr}, {1'b1, 32'h200});
    cyc(0,0,32'h200,0,1,0,0);
    check("flush_drop_held", {bus_req, bus_addr}, {1'b1, 32'h200});
    cyc(0,0,32'h200,0,0,0,0);
    check("flush_drop_wait", bus_req, 1);
    cyc(0,0,32'h200,0,0,1,32'hcafef00d);
    check("flush_discard", {bus_req, inst_valid_o, pc_read_ready, inst_o}, {3'b000, NOP});
    cyc(0,1,32'h200,0,0,0,0);
    check("flush_settle", {bus_req, inst_valid_o, pc_read_ready}, 3'b000);
    cyc(0,1,32'h200,0,0,0,0);
    check("flush_rereq", {bus_req, bus_addr}, {1'b1, 32'h200});
    cyc(1,0,0,0,0,0,0);

    // Timeout: request drops after TO cycles, one fault pulse, same pc retried.
    cyc(0,1,32'h300,0,0,0,0);
    for (int i = 0; i < int'(TO) - 1; i++) begin
      cyc(0,0,32'h300,0,0,0,0);
      check($sformatf("to_wait%0d", i), {bus_req, fetch_fault_o}, 2'b10);
    end
    cyc(0,0,32'h300,0,0,0,0);
    check("to_fire", {bus_req, fetch_fault_o, inst_valid_o}, 3'b010);
    cyc(0,1,32'h300,0,0,0,0);
    check("to_single_fault", {bus_req, fetch_fault_o, pc_read_ready}, 3'b000);
    cyc(0,1,32'h300,0,0,0,0);
    check("to_retry", {bus_req, bus_addr}, {1'b1, 32'h300});
    cyc(1,0,0,0,0,0,0);

    // Randomized run against the model; the bench plays the PC register.
    pc_reg = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) pc_reg = $urandom;
      else if ($urandom_range(0, 9) != 0) pc_reg[1:0] = 2'b00;
      ack_now = m_req && ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, pc_reg,
          $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, ack_now, $urandom);
      check("random", dut_vec(), mdl_vec());
      if (pc_read_ready) pc_reg = pc_reg + 32'd4;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
